// File: rtl/apb_rr_arbiter.sv
// Round-robin APB arbiter: grants the shared slave bus to one master per transfer.
// It decodes the slave from PADDR[SEL_LSB+3:SEL_LSB] and answers unmapped or timed-out
// transfers with an error.
module apb_rr_arbiter #(
    parameter int unsigned MASTER_PORTS = 2,
    parameter int unsigned SLAVE_PORTS  = 3,
    parameter int unsigned APB_WIDTH    = 16,
    parameter int unsigned SEL_LSB      = 12,
    parameter int unsigned TIMEOUT      = 255
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [MASTER_PORTS*APB_WIDTH-1:0] S_PADDR,
    input  logic [MASTER_PORTS-1:0]           S_PWRITE,
    input  logic [MASTER_PORTS-1:0]           S_PSELx,
    input  logic [MASTER_PORTS-1:0]           S_PENABLE,
    input  logic [MASTER_PORTS*APB_WIDTH-1:0] S_PWDATA,
    output logic [MASTER_PORTS*APB_WIDTH-1:0] S_PRDATA,
    output logic [MASTER_PORTS-1:0]           S_PREADY,
    output logic [MASTER_PORTS-1:0]           S_PSLVERR,
    output logic [APB_WIDTH-1:0]              M_PADDR,
    output logic                              M_PWRITE,
    output logic [SLAVE_PORTS-1:0]            M_PSELx,
    output logic                              M_PENABLE,
    output logic [APB_WIDTH-1:0]              M_PWDATA,
    input  logic [APB_WIDTH-1:0]              M_PRDATA,
    input  logic                              M_PREADY,
    output logic [2:0]                        grant_idx
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SETUP  = 2'd1;
    localparam logic [1:0] ACCESS = 2'd2;
    localparam logic [1:0] RESP   = 2'd3;

    localparam logic [9:0] TO_LAST = 10'(TIMEOUT - 1);

    logic [1:0]                        state_q, state_d;
    logic [2:0]                        gnt_q, gnt_d;
    logic [2:0]                        last_q, last_d;
    logic [APB_WIDTH-1:0]              addr_q, addr_d;
    logic                              write_q, write_d;
    logic [APB_WIDTH-1:0]              wdata_q, wdata_d;
    logic [3:0]                        sel_q, sel_d;
    logic                              err_q, err_d;
    logic [9:0]                        cnt_q, cnt_d;
    logic [MASTER_PORTS*APB_WIDTH-1:0] prdata_q, prdata_d;

    // Arbitration and winner-selection signals
    logic                              found;
    logic [2:0]                        win;
    int unsigned                       cand;
    int unsigned                       win_off;
    logic [MASTER_PORTS-1:0]           req_shift;
    logic [MASTER_PORTS-1:0]           write_shift;
    logic [MASTER_PORTS*APB_WIDTH-1:0] addr_shift;
    logic [MASTER_PORTS*APB_WIDTH-1:0] wdata_shift;
    logic [APB_WIDTH-1:0]              win_addr;
    logic [APB_WIDTH-1:0]              win_wdata;
    logic                              win_write;
    logic [3:0]                        dec_idx;
    logic                              dec_ok;

    // Response capture into a master's S_PRDATA slice
    logic                              cap_en;
    logic [2:0]                        cap_idx;
    logic [APB_WIDTH-1:0]              cap_data;

    // PENABLE from the masters carries no information the arbiter needs.
    logic unused_penable;
    assign unused_penable = ^S_PENABLE;

    // Round-robin pick: first requester scanning upward from last_q+1, with wrap.
    always_comb begin
        found     = 1'b0;
        win       = '0;
        cand      = 0;
        req_shift = '0;
        for (int unsigned i = 0; i < MASTER_PORTS; i++) begin
            cand      = (32'(last_q) + 1 + i) % MASTER_PORTS;
            req_shift = S_PSELx >> cand;
            if (!found && req_shift[0]) begin
                found = 1'b1;
                win   = 3'(cand);
            end
        end
        win_off     = 32'(win) * APB_WIDTH;
        addr_shift  = S_PADDR >> win_off;
        wdata_shift = S_PWDATA >> win_off;
        write_shift = S_PWRITE >> win;
        win_addr    = addr_shift[APB_WIDTH-1:0];
        win_wdata   = wdata_shift[APB_WIDTH-1:0];
        win_write   = write_shift[0];
        dec_idx     = win_addr[SEL_LSB+3:SEL_LSB];
        dec_ok      = (32'(dec_idx) < SLAVE_PORTS);
    end

    // Transfer FSM next state and response capture.
    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        last_d   = last_q;
        addr_d   = addr_q;
        write_d  = write_q;
        wdata_d  = wdata_q;
        sel_d    = sel_q;
        err_d    = err_q;
        cnt_d    = cnt_q;
        cap_en   = 1'b0;
        cap_idx  = gnt_q;
        cap_data = '0;
        unique case (state_q)
            IDLE: begin
                if (found) begin
                    gnt_d   = win;
                    last_d  = win;
                    addr_d  = win_addr;
                    write_d = win_write;
                    wdata_d = win_wdata;
                    sel_d   = dec_idx;
                    if (dec_ok) begin
                        err_d   = 1'b0;
                        state_d = SETUP;
                    end else begin
                        // Unmapped: skip the bus and answer with an error and zero data.
                        err_d   = 1'b1;
                        cap_en  = 1'b1;
                        cap_idx = win;
                        state_d = RESP;
                    end
                end
            end
            SETUP: state_d = ACCESS;
            ACCESS: begin
                cnt_d = cnt_q + 10'd1;
                if (M_PREADY) begin
                    cap_en   = 1'b1;
                    cap_data = M_PRDATA;
                    err_d    = 1'b0;
                    state_d  = RESP;
                end else if (cnt_q == TO_LAST) begin
                    cap_en  = 1'b1;
                    err_d   = 1'b1;
                    state_d = RESP;
                end
            end
            RESP: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        prdata_d = prdata_q;
        for (int unsigned m = 0; m < MASTER_PORTS; m++) begin
            if (cap_en && cap_idx == 3'(m)) begin
                prdata_d[m*APB_WIDTH +: APB_WIDTH] = cap_data;
            end
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            gnt_q    <= '0;
            last_q   <= 3'(MASTER_PORTS - 1);
            addr_q   <= '0;
            write_q  <= 1'b0;
            wdata_q  <= '0;
            sel_q    <= '0;
            err_q    <= 1'b0;
            cnt_q    <= '0;
            prdata_q <= '0;
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            last_q   <= last_d;
            addr_q   <= addr_d;
            write_q  <= write_d;
            wdata_q  <= wdata_d;
            sel_q    <= sel_d;
            err_q    <= err_d;
            cnt_q    <= cnt_d;
            prdata_q <= prdata_d;
        end
    end

    assign M_PADDR   = addr_q;
    assign M_PWRITE  = write_q;
    assign M_PWDATA  = wdata_q;
    assign M_PENABLE = (state_q == ACCESS);
    assign M_PSELx   = (state_q == SETUP || state_q == ACCESS) ? (SLAVE_PORTS'(1) << sel_q) : '0;
    assign S_PREADY  = (state_q == RESP) ? (MASTER_PORTS'(1) << gnt_q) : '0;
    assign S_PSLVERR = (state_q == RESP && err_q) ? (MASTER_PORTS'(1) << gnt_q) : '0;
    assign S_PRDATA  = prdata_q;
    assign grant_idx = gnt_q;

endmodule

// File: tb/tb_apb_rr_arbiter.sv
// Directed bench for apb_rr_arbiter: 2 masters, 3 slaves, TIMEOUT=4.
module tb_apb_rr_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] S_PADDR;
    logic [1:0]  S_PWRITE;
    logic [1:0]  S_PSELx;
    logic [1:0]  S_PENABLE;
    logic [31:0] S_PWDATA;
    logic [31:0] S_PRDATA;
    logic [1:0]  S_PREADY;
    logic [1:0]  S_PSLVERR;
    logic [15:0] M_PADDR;
    logic        M_PWRITE;
    logic [2:0]  M_PSELx;
    logic        M_PENABLE;
    logic [15:0] M_PWDATA;
    logic [15:0] M_PRDATA;
    logic        M_PREADY;
    logic [2:0]  grant_idx;

    int n_tests = 0;
    int n_fail  = 0;

    apb_rr_arbiter #(
        .MASTER_PORTS(2),
        .SLAVE_PORTS (3),
        .APB_WIDTH   (16),
        .SEL_LSB     (12),
        .TIMEOUT     (4)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .S_PADDR  (S_PADDR),
        .S_PWRITE (S_PWRITE),
        .S_PSELx  (S_PSELx),
        .S_PENABLE(S_PENABLE),
        .S_PWDATA (S_PWDATA),
        .S_PRDATA (S_PRDATA),
        .S_PREADY (S_PREADY),
        .S_PSLVERR(S_PSLVERR),
        .M_PADDR  (M_PADDR),
        .M_PWRITE (M_PWRITE),
        .M_PSELx  (M_PSELx),
        .M_PENABLE(M_PENABLE),
        .M_PWDATA (M_PWDATA),
        .M_PRDATA (M_PRDATA),
        .M_PREADY (M_PREADY),
        .grant_idx(grant_idx)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one clock; outputs are sampled and inputs driven 2 time units after the edge.
    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        S_PADDR = '0; S_PWRITE = '0; S_PSELx = '0; S_PENABLE = '0; S_PWDATA = '0;
        M_PRDATA = '0; M_PREADY = 1'b0;
        cyc(); cyc();
        check("rst_psel", 32'(M_PSELx), 0);
        check("rst_pen", 32'(M_PENABLE), 0);
        check("rst_paddr", 32'(M_PADDR), 0);
        check("rst_pready", 32'(S_PREADY), 0);
        check("rst_prdata", S_PRDATA, 0);
        check("rst_gidx", 32'(grant_idx), 0);

        // Single read, zero wait
        reset = 1'b0;
        S_PSELx = 2'b01; S_PADDR[15:0] = 16'h1004; M_PRDATA = 16'hBEEF; M_PREADY = 1'b1;
        cyc();
        check("rd_setup_psel", 32'(M_PSELx), 32'b010);
        check("rd_setup_pen", 32'(M_PENABLE), 0);
        check("rd_setup_addr", 32'(M_PADDR), 32'h1004);
        cyc();
        check("rd_acc_pen", 32'(M_PENABLE), 1);
        check("rd_acc_psel", 32'(M_PSELx), 32'b010);
        cyc();
        check("rd_resp_pready", 32'(S_PREADY), 32'b01);
        check("rd_resp_data", 32'(S_PRDATA[15:0]), 32'hBEEF);
        check("rd_resp_err", 32'(S_PSLVERR), 0);
        check("rd_resp_psel", 32'(M_PSELx), 0);
        S_PSELx = 2'b00;
        cyc();
        check("rd_idle_pready", 32'(S_PREADY), 0);

        // Contention after a fresh reset: grants must alternate 0,1,0,1
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        S_PADDR = {16'h2020, 16'h0010};
        S_PSELx = 2'b11;
        for (int k = 0; k < 4; k++) begin
            cyc();
            check("cn_gidx", 32'(grant_idx), 32'(k % 2));
            check("cn_psel", 32'(M_PSELx), (k % 2 == 0) ? 32'b001 : 32'b100);
            check("cn_addr", 32'(M_PADDR), (k % 2 == 0) ? 32'h0010 : 32'h2020);
            M_PRDATA = 16'(16'h1100 + k);
            cyc();
            cyc();
            check("cn_pready", 32'(S_PREADY), (k % 2 == 0) ? 32'b01 : 32'b10);
            if (k % 2 == 0) check("cn_data0", 32'(S_PRDATA[15:0]), 32'(16'h1100 + k));
            else            check("cn_data1", 32'(S_PRDATA[31:16]), 32'(16'h1100 + k));
            if (k == 1) check("cn_hold0", 32'(S_PRDATA[15:0]), 32'h1100);
            cyc();
            check("cn_pready_width", 32'(S_PREADY), 0);
        end
        S_PSELx = 2'b00;

        // Write with three wait states; PREADY coincides with the timeout limit and wins
        S_PSELx = 2'b01; S_PADDR[15:0] = 16'h2003; S_PWRITE = 2'b01; S_PWDATA[15:0] = 16'h00A5;
        M_PREADY = 1'b0;
        cyc();
        check("ws_setup_psel", 32'(M_PSELx), 32'b100);
        check("ws_setup_write", 32'(M_PWRITE), 1);
        for (int c = 2; c <= 4; c++) begin
            cyc();
            check("ws_wdata", 32'(M_PWDATA), 32'h00A5);
            check("ws_addr", 32'(M_PADDR), 32'h2003);
            check("ws_pen", 32'(M_PENABLE), 1);
            check("ws_no_pready", 32'(S_PREADY), 0);
        end
        cyc();
        check("ws_c5_pen", 32'(M_PENABLE), 1);
        M_PREADY = 1'b1; M_PRDATA = 16'h7777;
        cyc();
        check("ws_c6_pready", 32'(S_PREADY), 32'b01);
        check("ws_c6_err", 32'(S_PSLVERR), 0);
        check("ws_c6_data", 32'(S_PRDATA[15:0]), 32'h7777);
        S_PSELx = 2'b00; S_PWRITE = 2'b00; M_PREADY = 1'b0;
        cyc();

        // Decode miss from master 1
        S_PSELx = 2'b10; S_PADDR[31:16] = 16'hF000;
        cyc();
        check("dm_psel", 32'(M_PSELx), 0);
        check("dm_pready", 32'(S_PREADY), 32'b10);
        check("dm_err", 32'(S_PSLVERR), 32'b10);
        check("dm_data", 32'(S_PRDATA[31:16]), 0);
        S_PSELx = 2'b00;
        cyc();
        check("dm_idle", 32'(S_PREADY), 0);

        // Timeout: exactly 4 ACCESS cycles, then error with zero data
        S_PSELx = 2'b01; S_PADDR[15:0] = 16'h0100; M_PREADY = 1'b0;
        cyc();
        check("to_setup_psel", 32'(M_PSELx), 32'b001);
        for (int c = 0; c < 4; c++) begin
            cyc();
            check("to_acc_pen", 32'(M_PENABLE), 1);
            check("to_acc_pready", 32'(S_PREADY), 0);
        end
        cyc();
        check("to_pready", 32'(S_PREADY), 32'b01);
        check("to_err", 32'(S_PSLVERR), 32'b01);
        check("to_data", 32'(S_PRDATA[15:0]), 0);
        check("to_pen", 32'(M_PENABLE), 0);
        S_PSELx = 2'b00;
        cyc();
        S_PSELx = 2'b10; S_PADDR[31:16] = 16'h1008; M_PREADY = 1'b1; M_PRDATA = 16'h4242;
        cyc();
        check("to_next_psel", 32'(M_PSELx), 32'b010);
        check("to_next_gidx", 32'(grant_idx), 1);
        cyc();
        cyc();
        check("to_next_pready", 32'(S_PREADY), 32'b10);
        check("to_next_err", 32'(S_PSLVERR), 0);
        check("to_next_data", 32'(S_PRDATA[31:16]), 32'h4242);
        S_PSELx = 2'b00;
        cyc();

        // Reset during a wait-stated transfer from master 0
        S_PSELx = 2'b01; S_PADDR[15:0] = 16'h1000; S_PWDATA[15:0] = 16'h00A5; M_PREADY = 1'b0;
        cyc();
        cyc();
        cyc();
        check("rs_acc_pen", 32'(M_PENABLE), 1);
        reset = 1'b1;
        cyc();
        check("rs_psel", 32'(M_PSELx), 0);
        check("rs_pen", 32'(M_PENABLE), 0);
        check("rs_addr", 32'(M_PADDR), 0);
        check("rs_wdata", 32'(M_PWDATA), 0);
        check("rs_write", 32'(M_PWRITE), 0);
        check("rs_pready", 32'(S_PREADY), 0);
        check("rs_gidx", 32'(grant_idx), 0);
        reset = 1'b0;
        S_PSELx = 2'b11; S_PADDR[31:16] = 16'h2000; M_PREADY = 1'b1; M_PRDATA = 16'h5A5A;
        cyc();
        check("rs_first_gidx", 32'(grant_idx), 0);
        check("rs_first_psel", 32'(M_PSELx), 32'b010);
        cyc();
        cyc();
        check("rs_first_pready", 32'(S_PREADY), 32'b01);
        check("rs_first_data", 32'(S_PRDATA[15:0]), 32'h5A5A);
        S_PSELx = 2'b00;
        cyc();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/apb_rr_arbiter.md
Name: apb_rr_arbiter

Overview:
- Multi-master APB arbiter sitting between the vmicro16 cores and the shared slave bus.
- Grants the single shared APB bus to one core per transfer, using round-robin priority.
- Decodes the slave select from the upper address bits.
- Terminates transfers that hit an unmapped address or exceed the wait-state limit with an error response.

Parameters:
- MASTER_PORTS, 2, number of APB masters (cores), 1..8.
- SLAVE_PORTS, 3, number of APB slaves, 1..16.
- APB_WIDTH, 16, address and data width.
- SEL_LSB, 12, lowest address bit of the 4-bit slave index field PADDR[SEL_LSB+3:SEL_LSB].
- TIMEOUT, 255, maximum ACCESS cycles without M_PREADY before forced error; range 1..1023.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- S_PADDR  in  MASTER_PORTS*APB_WIDTH  per-master address, master i at [APB_WIDTH*i +: APB_WIDTH]
- S_PWRITE  in  MASTER_PORTS  per-master write strobe
- S_PSELx  in  MASTER_PORTS  per-master request/select
- S_PENABLE  in  MASTER_PORTS  per-master enable (ignored for arbitration)
- S_PWDATA  in  MASTER_PORTS*APB_WIDTH  per-master write data
- S_PRDATA  out  MASTER_PORTS*APB_WIDTH  per-master read data
- S_PREADY  out  MASTER_PORTS  per-master transfer-complete pulse
- S_PSLVERR  out  MASTER_PORTS  per-master error flag, valid with S_PREADY
- M_PADDR  out  APB_WIDTH  shared slave address
- M_PWRITE  out  1  shared write strobe
- M_PSELx  out  SLAVE_PORTS  one-hot slave select
- M_PENABLE  out  1  shared enable
- M_PWDATA  out  APB_WIDTH  shared write data
- M_PRDATA  in  APB_WIDTH  shared slave read data
- M_PREADY  in  1  shared slave ready
- grant_idx  out  3  index of the current or last granted master (debug)

Behaviour:
- Clocking and reset: one clock. Reset is synchronous and active-high.
- Reset values:
  - FSM goes to IDLE.
  - All M_* outputs are 0.
  - S_PREADY = 0, S_PSLVERR = 0, S_PRDATA = 0.
  - grant_idx = 0.
  - last_grant pointer = MASTER_PORTS-1, so master 0 wins first.
  - Timeout counter = 0.
- Reset mid-transfer: drops M_PSELx and M_PENABLE in the next cycle. No S_PREADY is issued for the aborted transfer.
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - If any S_PSELx bit is set, select the first requester scanning from (last_grant+1) mod MASTER_PORTS upward, with wrap.
  - Latch the winner's index, PADDR, PWRITE and PWDATA into registers. Update last_grant and grant_idx.
  - If the decoded slave index < SLAVE_PORTS, go to SETUP. Otherwise go directly to RESP with the error flag set; no slave is selected.
  - If no requests, stay in IDLE.
- SETUP (1 cycle):
  - M_PSELx is one-hot at the decoded index; M_PENABLE = 0.
  - M_PADDR, M_PWRITE, M_PWDATA come from the latched registers.
  - Next state is ACCESS.
- ACCESS:
  - M_PSELx is held; M_PENABLE = 1; the timeout counter increments each cycle.
  - If M_PREADY = 1: capture M_PRDATA, clear the error flag, go to RESP.
  - Else if the counter reaches TIMEOUT-1: capture 0 as read data, set the error flag, go to RESP.
  - M_PREADY takes priority over timeout in the same cycle.
- RESP (1 cycle):
  - M_PSELx = 0 and M_PENABLE = 0.
  - For the granted master only: S_PREADY = 1, S_PSLVERR = error flag, and its S_PRDATA slice = captured data.
  - All other S_PREADY bits are 0. S_PRDATA slices of non-granted masters hold their previous value.
  - Counter clears. Next state is IDLE.
- Latency: a request sampled in IDLE at cycle 0 with a zero-wait slave gives:
  - SETUP at cycle 1;
  - ACCESS at cycle 2, with PREADY sampled;
  - S_PREADY at cycle 3.
  - Each slave wait state adds one cycle. Back-to-back grants are separated by at least one IDLE cycle.
- Master rule: a master holds S_PSELx, S_PADDR, S_PWRITE and S_PWDATA stable until it sees its S_PREADY, then deasserts S_PSELx in the following cycle. Requests raised while another master is granted wait; they are not dropped.
- Write transfers: S_PRDATA is updated with the captured M_PRDATA (don't-care value), PSLVERR still valid.
- Fairness: with all masters requesting continuously, grants rotate 0,1,…,MASTER_PORTS-1,0…; no master waits more than MASTER_PORTS-1 transfers.
- MASTER_PORTS = 1: the arbiter degenerates to a fixed grant; the FSM is unchanged.

Test Plan:
- Single read: master 0 reads 0x1004 (SEL_LSB=12, slave 1), slave returns 0xBEEF with zero wait → M_PSELx=3'b010 at cycle 1, M_PENABLE at cycle 2, S_PREADY[0]=1 with S_PRDATA[15:0]=0xBEEF at cycle 3, S_PSLVERR[0]=0.
- Contention: masters 0 and 1 both request at the same cycle after reset, then continuously → grants 0,1,0,1; grant_idx sequence matches; each S_PREADY is one cycle wide; no overlapping M_PSELx.
- Wait states: slave holds PREADY low for 3 ACCESS cycles on a write of 0x00A5 to 0x2003 → M_PWDATA=0x00A5 and M_PADDR stable throughout; S_PREADY arrives at cycle 6.
- Decode miss: master 1 accesses 0xF000 with SLAVE_PORTS=3 → M_PSELx stays 0; next cycle S_PREADY[1]=1, S_PSLVERR[1]=1, S_PRDATA slice=0.
- Timeout: TIMEOUT=4, slave never asserts PREADY → exactly 4 ACCESS cycles, then RESP with S_PSLVERR=1 and data 0; arbiter returns to IDLE and serves the next request normally.
- Reset mid-ACCESS: assert reset during a wait-stated transfer → next cycle all M_* = 0 and S_PREADY = 0; after release, master 0 wins first grant.
